// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU ops and pipeline-register layouts shared by the core
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;
  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    alu_op_t     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } id_ex_t;
  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] store;
  } ex_mem_t;
  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_wb_t;
  function automatic alu_op_t funct_alu(input logic [5:0] fn);
    return fn == FN_SUB ? ALU_SUB :
           fn == FN_AND ? ALU_AND :
           fn == FN_OR  ? ALU_OR  :
           fn == FN_SLT ? ALU_SLT :
           fn == FN_ADD ? ALU_ADD : ALU_ADD;
  endfunction
endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational ALU for the EX stage
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);
  always_comb
    result = alu_op == ALU_SUB ? a - b :
             alu_op == ALU_AND ? a & b :
             alu_op == ALU_OR  ? a | b :
             alu_op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
endmodule

// File: rtl/mips_pipeline_main.sv
// mips_pipeline_main: five-stage MIPS-subset core with forwarding, load-use stall and branch/jump flush
module mips_pipeline_main
  import mips_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input logic [31:0] instMemory [0:65535],
  input logic [31:0] regMem [0:31]
);
  logic [31:0] pc;
  logic [31:0] regfile [0:31];
  logic [31:0] dmem [0:255];
  if_id_t  r_if_id;
  id_ex_t  r_id_ex;
  ex_mem_t r_ex_mem;
  mem_wb_t r_mem_wb;
  id_ex_t  w_dec;
  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt;
  logic        w_jump, w_stall, w_taken;
  logic [31:0] w_fa, w_fb, w_b, w_alu, w_target, w_load;
  assign w_op = r_if_id.instr[31:26];
  assign w_rs = r_if_id.instr[25:21];
  assign w_rt = r_if_id.instr[20:16];
  always_comb begin
    w_dec           = '0;
    w_dec.pc        = r_if_id.pc;
    w_dec.rs        = w_rs;
    w_dec.rt        = w_rt;
    w_dec.imm       = {{16{r_if_id.instr[15]}}, r_if_id.instr[15:0]};
    w_dec.rs_val    = r_mem_wb.reg_write && |r_mem_wb.rd && r_mem_wb.rd == w_rs ? r_mem_wb.data : regfile[w_rs];
    w_dec.rt_val    = r_mem_wb.reg_write && |r_mem_wb.rd && r_mem_wb.rd == w_rt ? r_mem_wb.data : regfile[w_rt];
    w_dec.alu_op    = w_op == OP_RTYPE ? funct_alu(r_if_id.instr[5:0]) : ALU_ADD;
    w_dec.reg_write = w_op inside {OP_RTYPE, OP_ADDI, OP_LW};
    w_dec.mem_read  = w_op == OP_LW;
    w_dec.mem_write = w_op == OP_SW;
    w_dec.branch    = w_op == OP_BEQ;
    w_dec.alu_src   = w_op inside {OP_ADDI, OP_LW, OP_SW};
    w_dec.rd        = w_op == OP_RTYPE ? r_if_id.instr[15:11] : w_rt;
  end
  assign w_jump  = w_op == OP_J;
  assign w_stall = r_id_ex.mem_read && (r_id_ex.rd == w_rs || r_id_ex.rd == w_rt);
  assign w_fa = r_ex_mem.reg_write && |r_ex_mem.rd && r_ex_mem.rd == r_id_ex.rs ? r_ex_mem.alu :
                r_mem_wb.reg_write && |r_mem_wb.rd && r_mem_wb.rd == r_id_ex.rs ? r_mem_wb.data : r_id_ex.rs_val;
  assign w_fb = r_ex_mem.reg_write && |r_ex_mem.rd && r_ex_mem.rd == r_id_ex.rt ? r_ex_mem.alu :
                r_mem_wb.reg_write && |r_mem_wb.rd && r_mem_wb.rd == r_id_ex.rt ? r_mem_wb.data : r_id_ex.rt_val;
  assign w_b      = r_id_ex.alu_src ? r_id_ex.imm : w_fb;
  assign w_taken  = r_id_ex.branch && w_fa == w_fb;
  assign w_target = r_id_ex.pc + 32'd1 + r_id_ex.imm;
  assign w_load   = dmem[r_ex_mem.alu[7:0]];
  mips_alu u_alu (.a(w_fa), .b(w_b), .alu_op(r_id_ex.alu_op), .result(w_alu));
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= '0;
      r_if_id  <= '0;
      r_id_ex  <= '0;
      r_ex_mem <= '0;
      r_mem_wb <= '0;
      for (int i = 0; i < 32; i++) regfile[i] <= i == 0 ? 32'd0 : regMem[i];
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else begin
      pc       <= w_taken ? w_target : w_stall ? pc : w_jump ? {r_if_id.pc[31:26], r_if_id.instr[25:0]} : pc + 32'd1;
      r_if_id  <= w_taken ? '0 : w_stall ? r_if_id : w_jump ? '0 : {pc, instMemory[pc[15:0]]};
      r_id_ex  <= w_taken || w_stall ? '0 : w_dec;
      r_ex_mem <= {r_id_ex.reg_write, r_id_ex.mem_read, r_id_ex.mem_write, r_id_ex.rd, w_alu, w_fb};
      r_mem_wb <= {r_ex_mem.reg_write, r_ex_mem.rd, r_ex_mem.mem_read ? w_load : r_ex_mem.alu};
      if (r_ex_mem.mem_write) dmem[r_ex_mem.alu[7:0]] <= r_ex_mem.store;
      if (r_mem_wb.reg_write && |r_mem_wb.rd) regfile[r_mem_wb.rd] <= r_mem_wb.data;
    end
  end
endmodule

// File: tb/tb_mips_pipeline_main.sv
// tb_mips_pipeline_main: directed pipeline-timing checks plus random programs against an ISA-level model
module tb_mips_pipeline_main;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem [0:65535];
  logic [31:0] rmem [0:31];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_mem [0:255];
  int errors = 0;
  int checks = 0;
  mips_pipeline_main dut (.clk(clk), .rst(rst), .instMemory(imem), .regMem(rmem));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] r_ins(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] j_ins(input int t);
    return {6'h02, 26'(t)};
  endfunction
  // Architectural (one instruction at a time) interpreter of the instruction set
  task automatic model(input logic [31:0] last);
    logic [31:0] pc, npc, ins, a, b, imm, addr, val;
    logic [5:0]  fn;
    logic [4:0]  dest;
    logic        we;
    int          steps;
    for (int i = 0; i < 32; i++) m_reg[i] = i == 0 ? 32'd0 : rmem[i];
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    pc = '0;
    steps = 0;
    while (pc != last && steps < 1000) begin
      ins  = imem[pc[15:0]];
      a    = m_reg[ins[25:21]];
      b    = m_reg[ins[20:16]];
      imm  = {{16{ins[15]}}, ins[15:0]};
      addr = a + imm;
      npc  = pc + 32'd1;
      we   = 1'b0;
      dest = ins[20:16];
      val  = '0;
      fn   = ins[5:0];
      case (ins[31:26])
        6'h00: begin
          we   = 1'b1;
          dest = ins[15:11];
          val  = fn == 6'h22 ? a - b : fn == 6'h24 ? a & b : fn == 6'h25 ? a | b :
                 fn == 6'h2A ? ($signed(a) < $signed(b) ? 32'd1 : 32'd0) : a + b;
        end
        6'h08: begin we = 1'b1; val = addr; end
        6'h23: begin we = 1'b1; val = m_mem[addr[7:0]]; end
        6'h2B: m_mem[addr[7:0]] = b;
        6'h04: if (a == b) npc = pc + 32'd1 + imm;
        6'h02: npc = {pc[31:26], ins[25:0]};
        default: ;
      endcase
      if (we && dest != 5'd0) m_reg[dest] = val;
      pc = npc;
      steps++;
    end
    check("model_terminates", pc, last);
  endtask
  task automatic gen_prog();
    logic [5:0]  fns [0:6];
    logic [15:0] imm;
    int k, rs, rt, rd;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h27};
    for (int a = 0; a < 32; a++) imem[a] = '0;
    for (int a = 0; a < 24; a++) begin
      k   = int'($urandom_range(0, 9));
      rs  = int'($urandom_range(0, 7));
      rt  = int'($urandom_range(0, 7));
      rd  = int'($urandom_range(0, 7));
      imm = $urandom_range(0, 1) == 1 ? 16'($urandom_range(0, 7)) : 16'($urandom);
      case (k)
        3:       imem[a] = i_ins(6'h08, rs, rt, imm);
        4, 5:    imem[a] = i_ins(6'h23, rs, rt, 16'($urandom_range(0, 15)));
        6:       imem[a] = i_ins(6'h2B, rs, rt, 16'($urandom_range(0, 15)));
        7:       imem[a] = i_ins(6'h04, rs, rt, 16'($urandom_range(0, 23 - a)));
        8:       imem[a] = i_ins(6'h0D, rs, rt, imm);
        default: imem[a] = r_ins(rd, rs, rt, fns[$urandom_range(0, 6)]);
      endcase
    end
    imem[24] = j_ins(24);
  endtask
  initial begin
    for (int a = 0; a < 65536; a++) imem[a] = '0;
    for (int i = 0; i < 32; i++) rmem[i] = 32'(i);
    rmem[0] = 32'd5;
    imem[0]  = r_ins(3, 1, 2, 6'h20);
    imem[1]  = r_ins(4, 2, 3, 6'h20);
    imem[2]  = r_ins(5, 3, 4, 6'h20);
    imem[3]  = r_ins(11, 1, 0, 6'h20);
    imem[7]  = i_ins(6'h04, 1, 11, 16'd3);
    imem[8]  = i_ins(6'h08, 0, 6, 16'd99);
    imem[9]  = i_ins(6'h08, 0, 9, 16'd99);
    imem[10] = i_ins(6'h08, 0, 12, 16'd99);
    imem[11] = r_ins(15, 13, 14, 6'h2A);
    imem[12] = i_ins(6'h2B, 17, 3, 16'd3);
    imem[13] = i_ins(6'h23, 14, 16, 16'd6);
    imem[14] = i_ins(6'h23, 0, 7, 16'd20);
    imem[15] = r_ins(8, 7, 1, 6'h20);
    imem[19] = j_ins(0);
    imem[20] = i_ins(6'h08, 0, 6, 16'd77);
    tick(2);
    check("reset_pc", dut.pc, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("reset_r%0d", i), dut.regfile[i], i == 0 ? 32'd0 : 32'(i));
    rst = 1'b1;
    tick(5);
    check("fwd_r4_before", dut.regfile[4], 32'd4);
    tick(1);
    check("fwd_r4", dut.regfile[4], 32'd5);
    check("fwd_r5_before", dut.regfile[5], 32'd5);
    tick(1);
    check("fwd_r5", dut.regfile[5], 32'd8);
    tick(12);
    check("stall_r8_before", dut.regfile[8], 32'd8);
    tick(1);
    check("stall_r8", dut.regfile[8], 32'd4);
    check("sw_dmem20", dut.dmem[20], 32'd3);
    check("lw_r16", dut.regfile[16], 32'd3);
    check("squash_r6", dut.regfile[6], 32'd6);
    check("squash_r9", dut.regfile[9], 32'd9);
    check("squash_r12", dut.regfile[12], 32'd12);
    check("slt_r15", dut.regfile[15], 32'd1);
    tick(1);
    check("jump_pc0", dut.pc, 32'd0);
    tick(1);
    check("jump_pc1", dut.pc, 32'd1);
    tick(100);
    check("loop_r3", dut.regfile[3], 32'd3);
    check("loop_r4", dut.regfile[4], 32'd5);
    check("loop_r5", dut.regfile[5], 32'd8);
    check("loop_r6", dut.regfile[6], 32'd6);
    check("loop_r7", dut.regfile[7], 32'd3);
    check("loop_r8", dut.regfile[8], 32'd4);
    check("loop_r11", dut.regfile[11], 32'd1);
    check("loop_r15", dut.regfile[15], 32'd1);
    check("loop_r16", dut.regfile[16], 32'd3);
    check("loop_dmem20", dut.dmem[20], 32'd3);
    tick(3);
    rst = 1'b0;
    tick(2);
    check("midrst_pc", dut.pc, 32'd0);
    check("midrst_r5", dut.regfile[5], 32'd5);
    check("midrst_r8", dut.regfile[8], 32'd8);
    check("midrst_dmem20", dut.dmem[20], 32'd0);
    rst = 1'b1;
    tick(6);
    check("midrst_r5_held", dut.regfile[5], 32'd5);
    tick(1);
    check("midrst_r5_new", dut.regfile[5], 32'd8);
    for (int it = 0; it < 8; it++) begin
      gen_prog();
      for (int i = 0; i < 32; i++) rmem[i] = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 4)) : $urandom;
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(150);
      model(32'd24);
      for (int i = 0; i < 32; i++) check($sformatf("rnd%0d_r%0d", it, i), dut.regfile[i], m_reg[i]);
      for (int i = 0; i < 256; i++) check($sformatf("rnd%0d_m%0d", it, i), dut.dmem[i], m_mem[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
